// File: rtl/bullet_line_renderer_pkg.sv
// bullet_pkg: bullet table layout, entry struct and scan FSM states for bullet_line_renderer.
package bullet_pkg;
   localparam int BULLET_SLOTS = 32;
   localparam int ENTRY_W      = 24;
   localparam int HPOS_W       = 12;
   localparam int VPOS_W       = 11;
   localparam int ACTIVE_BIT   = 23;
   localparam int HPOS_LSB     = 11;
   localparam int VPOS_LSB     = 0;
   typedef struct packed {
      logic              active;
      logic [HPOS_W-1:0] hor_pos;
      logic [VPOS_W-1:0] ver_pos;
   } bullet_entry_t;
   typedef enum logic [1:0] {IDLE, SCAN, SWAP} scan_state_t;
endpackage

// File: rtl/bullet_line_renderer_if.sv
// bullet_line_renderer_if: bullet table, video timing inputs and hit/status outputs.
// ovf_count exists only when BULLET_OVF_COUNT_EN is defined.
interface bullet_line_renderer_if;
   import bullet_pkg::*;
   logic [BULLET_SLOTS*ENTRY_W-1:0] bullets;
   logic                            line_start;
   logic [VPOS_W-1:0]               next_line;
   logic [HPOS_W-1:0]               hcount;
   logic                            pixel_active;
   logic                            hit;
   logic                            line_overflow;
   logic                            scan_busy;
`ifdef BULLET_OVF_COUNT_EN
   logic [7:0]                      ovf_count;
   modport master (output bullets, line_start, next_line, hcount, pixel_active,
                   input hit, line_overflow, scan_busy, ovf_count);
   modport slave  (input bullets, line_start, next_line, hcount, pixel_active,
                   output hit, line_overflow, scan_busy, ovf_count);
`else
   modport master (output bullets, line_start, next_line, hcount, pixel_active,
                   input hit, line_overflow, scan_busy);
   modport slave  (input bullets, line_start, next_line, hcount, pixel_active,
                   output hit, line_overflow, scan_busy);
`endif
endinterface

// File: rtl/bullet_line_renderer_slot_bank.sv
// bullet_slot_bank: double-buffered per-line hor_pos slots with registered pixel hit compare.
module bullet_slot_bank
   import bullet_pkg::*;
#(
   parameter int DIMENSION    = 10,
   parameter int MAX_PER_LINE = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              push_i,
   input  logic [HPOS_W-1:0] push_hpos_i,
   input  logic              swap_i,
   output logic              full_o,
   output logic              ovf_o,
   input  logic [HPOS_W-1:0] hcount_i,
   input  logic              pixel_active_i,
   output logic              hit_o
);
   localparam int CNT_W = $clog2(MAX_PER_LINE + 1);
   logic [HPOS_W-1:0]       sh_hpos_q [MAX_PER_LINE];
   logic [HPOS_W-1:0]       disp_hpos_q [MAX_PER_LINE];
   logic [CNT_W-1:0]        sh_cnt_q;
   logic                    sh_ovf_q;
   logic [MAX_PER_LINE-1:0] disp_valid_q;
   logic [MAX_PER_LINE-1:0] in_range;
   logic                    hit_q;
   logic                    hit_d;
   assign full_o = sh_cnt_q == CNT_W'(MAX_PER_LINE);
   assign ovf_o  = sh_ovf_q;
   assign hit_o  = hit_q;
   // 13-bit compare so a bullet near column 4095 does not wrap to column 0
   for (genvar g = 0; g < MAX_PER_LINE; g++) begin : g_cmp
      assign in_range[g] = disp_valid_q[g]
                        && ({1'b0, disp_hpos_q[g]} <= {1'b0, hcount_i})
                        && ({1'b0, hcount_i} < {1'b0, disp_hpos_q[g]} + 13'(DIMENSION));
   end
   assign hit_d = pixel_active_i && |in_range;
   always_ff @(posedge clock) begin
      if (reset) begin
         sh_cnt_q     <= '0;
         sh_ovf_q     <= 1'b0;
         disp_valid_q <= '0;
         hit_q        <= 1'b0;
      end else begin
         hit_q <= hit_d;
         if (clear_i) begin
            sh_cnt_q <= '0;
            sh_ovf_q <= 1'b0;
         end else if (push_i) begin
            if (full_o) sh_ovf_q <= 1'b1;
            else sh_cnt_q <= sh_cnt_q + 1'b1;
         end
         if (swap_i)
            for (int i = 0; i < MAX_PER_LINE; i++) disp_valid_q[i] <= CNT_W'(i) < sh_cnt_q;
      end
   end
   always_ff @(posedge clock) begin
      for (int i = 0; i < MAX_PER_LINE; i++) begin
         if (!clear_i && push_i && !full_o && CNT_W'(i) == sh_cnt_q) sh_hpos_q[i] <= push_hpos_i;
         if (swap_i) disp_hpos_q[i] <= sh_hpos_q[i];
      end
   end
endmodule

// File: rtl/bullet_line_renderer.sv
// bullet_line_renderer: scans the bullet table in hblank and flags pixels inside a bullet.
// Optional swap-overflow counter on bus.ovf_count when BULLET_OVF_COUNT_EN is defined.
module bullet_line_renderer
   import bullet_pkg::*;
#(
   parameter int DIMENSION    = 10,
   parameter int MAX_PER_LINE = 8
) (
   input logic                    clock,
   input logic                    reset,
   bullet_line_renderer_if.slave  bus
);
   scan_state_t         state_q;
   logic [4:0]          index_q;
   logic [VPOS_W-1:0]   target_q;
   logic                scan_busy_q;
   logic                line_overflow_q;
   bullet_entry_t       entry;
   logic                qualify;
   logic                push;
   logic                swap;
   logic                full;
   logic                sh_ovf;
   assign entry   = bullet_entry_t'(bus.bullets[int'(index_q)*ENTRY_W +: ENTRY_W]);
   // 12-bit sum keeps ver_pos near 2047 from wrapping below the target
   assign qualify = entry.active
                 && ({1'b0, entry.ver_pos} <= {1'b0, target_q})
                 && ({1'b0, target_q} < {1'b0, entry.ver_pos} + 12'(DIMENSION));
   assign push    = state_q == SCAN && qualify;
   assign swap    = state_q == SWAP && !bus.line_start;
   bullet_slot_bank #(.DIMENSION(DIMENSION), .MAX_PER_LINE(MAX_PER_LINE)) u_bank (
      .clock          (clock),
      .reset          (reset),
      .clear_i        (bus.line_start),
      .push_i         (push),
      .push_hpos_i    (entry.hor_pos),
      .swap_i         (swap),
      .full_o         (full),
      .ovf_o          (sh_ovf),
      .hcount_i       (bus.hcount),
      .pixel_active_i (bus.pixel_active),
      .hit_o          (bus.hit)
   );
   assign bus.scan_busy     = scan_busy_q;
   assign bus.line_overflow = line_overflow_q;
`ifdef BULLET_OVF_COUNT_EN
   logic [7:0] ovf_count_q;
   assign bus.ovf_count = ovf_count_q;
   always_ff @(posedge clock) begin
      if (reset) ovf_count_q <= '0;
      else if (swap && sh_ovf && ovf_count_q != 8'hff) ovf_count_q <= ovf_count_q + 1'b1;
   end
`endif
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         index_q         <= '0;
         target_q        <= '0;
         scan_busy_q     <= 1'b0;
         line_overflow_q <= 1'b0;
      end else if (bus.line_start) begin
         state_q     <= SCAN;
         index_q     <= '0;
         target_q    <= bus.next_line;
         scan_busy_q <= 1'b1;
      end else begin
         unique case (state_q)
            SCAN: begin
               index_q <= index_q + 1'b1;
               if (index_q == 5'(BULLET_SLOTS - 1)) state_q <= SWAP;
            end
            SWAP: begin
               state_q         <= IDLE;
               scan_busy_q     <= 1'b0;
               line_overflow_q <= sh_ovf;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bullet_line_renderer.sv
// tb_bullet_line_renderer: directed vectors for bullet_line_renderer with hand-computed expectations.
module tb_bullet_line_renderer;
   import bullet_pkg::*;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   bullet_line_renderer_if bus ();
   bullet_line_renderer #(.DIMENSION(10), .MAX_PER_LINE(8)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );
   initial forever #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic set_entry(input int k, input logic act, input logic [11:0] h, input logic [10:0] v);
      bus.bullets[k*24 +: 24] = {act, h, v};
   endtask
   task automatic pulse(input logic [10:0] n);
      @(posedge clock); #1;
      bus.line_start = 1'b1;
      bus.next_line  = n;
      @(posedge clock); #1;
      bus.line_start = 1'b0;
   endtask
   task automatic wait_swap(input string tag);
      int n = 0;
      while (bus.scan_busy && n < 60) begin
         @(posedge clock); #1;
         n++;
      end
      check(tag, n, 33);
   endtask
   task automatic line(input logic [10:0] n);
      pulse(n);
      wait_swap("scan_latency");
   endtask
   task automatic px(input string tag, input logic [11:0] hc, input logic pa, input logic exp);
      @(posedge clock); #1;
      bus.hcount       = hc;
      bus.pixel_active = pa;
      @(posedge clock); #1;
      bus.pixel_active = 1'b0;
      check(tag, bus.hit, exp);
   endtask
   initial begin
      logic [7:0] ovf_before;
      ovf_before       = '0;
      bus.bullets      = '0;
      bus.line_start   = 1'b0;
      bus.next_line    = '0;
      bus.hcount       = '0;
      bus.pixel_active = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_hit", bus.hit, 0);
      check("rst_busy", bus.scan_busy, 0);
      check("rst_ovf", bus.line_overflow, 0);
      reset = 1'b0;
      set_entry(5, 1'b1, 12'd100, 11'd200);
      pulse(11'd205);
      check("busy_after_start", bus.scan_busy, 1);
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("midscan_rst_busy", bus.scan_busy, 0);
      check("midscan_rst_hit", bus.hit, 0);
      repeat (40) @(posedge clock);
      px("midscan_rst_empty", 12'd100, 1'b1, 1'b0);
      line(11'd205);
      px("single_99", 12'd99, 1'b1, 1'b0);
      px("single_100", 12'd100, 1'b1, 1'b1);
      px("single_105", 12'd105, 1'b1, 1'b1);
      px("single_109", 12'd109, 1'b1, 1'b1);
      px("single_110", 12'd110, 1'b1, 1'b0);
      px("single_inactive_px", 12'd100, 1'b0, 1'b0);
      check("single_no_ovf", bus.line_overflow, 0);
      line(11'd199);
      px("vert_199", 12'd100, 1'b1, 1'b0);
      line(11'd209);
      px("vert_209", 12'd100, 1'b1, 1'b1);
      line(11'd210);
      px("vert_210", 12'd100, 1'b1, 1'b0);
      set_entry(5, 1'b0, 12'd100, 11'd200);
      line(11'd205);
      px("inactive_entry", 12'd100, 1'b1, 1'b0);
`ifdef BULLET_OVF_COUNT_EN
      ovf_before = bus.ovf_count;
`endif
      for (int i = 0; i < 10; i++) set_entry(i, 1'b1, 12'(20 * i), 11'd50);
      line(11'd52);
      check("ovf_flag", bus.line_overflow, 1);
      px("ovf_0", 12'd0, 1'b1, 1'b1);
      px("ovf_140", 12'd140, 1'b1, 1'b1);
      px("ovf_160", 12'd160, 1'b1, 1'b0);
      px("ovf_180", 12'd180, 1'b1, 1'b0);
`ifdef BULLET_OVF_COUNT_EN
      check("ovf_count", bus.ovf_count, 32'(ovf_before) + 1);
`endif
      line(11'd100);
      check("ovf_cleared", bus.line_overflow, 0);
      px("ovf_gone", 12'd0, 1'b1, 1'b0);
      bus.bullets = '0;
      for (int i = 0; i < 9; i++) set_entry(i, 1'b1, 12'd300, 11'd50);
      line(11'd55);
      check("dup_ovf", bus.line_overflow, 1);
      px("dup_hit", 12'd305, 1'b1, 1'b1);
      bus.bullets = '0;
      set_entry(3, 1'b1, 12'd500, 11'd300);
      set_entry(20, 1'b1, 12'd700, 11'd5);
      pulse(11'd300);
      repeat (18) @(posedge clock);
      #1;
      check("restart_busy", bus.scan_busy, 1);
      pulse(11'd10);
      wait_swap("restart_latency");
      px("restart_old_line", 12'd500, 1'b1, 1'b0);
      px("restart_new_line", 12'd700, 1'b1, 1'b1);
      bus.bullets = '0;
      set_entry(0, 1'b1, 12'd4090, 11'd2045);
      line(11'd2047);
      px("wrap_4090", 12'd4090, 1'b1, 1'b1);
      px("wrap_4095", 12'd4095, 1'b1, 1'b1);
      for (int h = 0; h < 4; h++) px("wrap_low", 12'(h), 1'b1, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bullet_line_renderer.md
Name: bullet_line_renderer

Overview:
- Reads the 768-bit bullet table produced by the bullet-motion block and tells the VGA pixel pipeline whether the current pixel lies inside a bullet.
- During horizontal blanking it scans all 32 entries, one per clock, and collects the bullets that cover the next scanline into a small slot list.
- During active video it compares hcount against that list and drives a registered hit flag to the colour mux.

Parameters:
- DIMENSION, 10, bullet square side in pixels (same value as the motion block).
- MAX_PER_LINE, 8, slots per scanline; extra bullets on a line are dropped.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bullets  in  768  bullet table; entry k = bullets[24k+23:24k]; bit 23 active, [22:11] hor_pos (12b), [10:0] ver_pos (11b)
- line_start  in  1  one-cycle pulse at start of horizontal blank
- next_line  in  11  scanline to be drawn next; sampled with line_start
- hcount  in  12  current pixel column
- pixel_active  in  1  high during visible pixels
- hit  out  1  registered; current pixel is inside a bullet
- line_overflow  out  1  more than MAX_PER_LINE bullets hit the line now displayed
- scan_busy  out  1  high while the scan is in progress

Behaviour:
- Reset (synchronous, active-high; clock named clock, reset named reset): state IDLE, index=0, both slot banks invalid, hit=0, line_overflow=0, scan_busy=0.
- FSM IDLE -> SCAN on line_start:
  - latch target=next_line.
  - clear all shadow-bank valid bits and the shadow overflow flag.
  - index=0; scan_busy=1.
- SCAN, one entry per cycle:
  - entry index qualifies when active=1 and ver_pos <= target < ver_pos+DIMENSION.
  - The sum is computed in 12 bits, so ver_pos near 2047 does not wrap.
  - A qualifying entry writes hor_pos into the next free shadow slot.
  - If all MAX_PER_LINE slots are full, the entry is dropped and shadow overflow is set.
- SCAN at index 31 -> SWAP (1 cycle):
  - shadow bank becomes display bank; line_overflow takes the shadow overflow value.
  - scan_busy=0, then IDLE.
  - Total scan latency from line_start to new display bank = 33 cycles; the timing generator guarantees at least 34 cycles of blank after line_start.
- line_start while in SCAN or SWAP:
  - the scan restarts with the new next_line; the shadow bank is cleared.
  - the display bank is untouched (an aborted scan is never swapped in).
- The bullets input may change mid-scan. Each entry is sampled once, at its own index cycle; there is no snapshot.
- Pixel path, 1-cycle latency:
  - hit(t+1) = pixel_active(t) AND OR over valid display slots of (hor_pos <= hcount(t) < hor_pos+DIMENSION).
  - The compare is 13-bit, so no wrap at hcount=4095.
  - hit=0 whenever pixel_active was 0.
- Display bank persists until the next SWAP; no line_start means the same list is reused.
- Duplicate hor_pos values occupy separate slots.

Optional Feature:
- Macro BULLET_OVF_COUNT_EN.
- Defined:
  - adds output ovf_count[7:0]: count of swaps with shadow overflow set.
  - saturates at 255; cleared by reset.
- Undefined: port absent; no counter logic.

Decomposition:
- Package bullet_pkg:
  - BULLET_SLOTS=32, ENTRY_W=24, HPOS_W=12, VPOS_W=11.
  - field offsets ACTIVE_BIT=23, HPOS_LSB=11, VPOS_LSB=0.
  - typedef bullet_entry_t (packed struct active/hor_pos/ver_pos).
  - FSM state enum.
- Sub-module bullet_slot_bank:
  - double-buffered MAX_PER_LINE hor_pos/valid storage with clear, push, swap and full.
  - the per-slot pixel comparators feeding an OR tree.
- The top level holds the FSM, index counter and vertical qualify logic.

Test Plan:
- Reset mid-scan: line_start, then reset at cycle 10 -> hit=0, scan_busy=0, display bank empty (pixel_active with hcount=100 gives hit=0).
- Single bullet: entry 5 = {1, hpos=100, vpos=200}; line_start with next_line=205; wait 34 cycles -> hit=1 for hcount 100..109 (one cycle late), 0 at 99 and 110.
- Vertical edges:
  - next_line=199 -> no hit on the line.
  - next_line=209 -> hit.
  - next_line=210 -> no hit.
  - entry with active=0 and vpos=200, next_line=205 -> no hit.
- Overflow: 10 active entries with vpos=50, hpos=0,20,..,180; next_line=52 -> line_overflow=1.
  - Only the first 8 by index are drawn: hit at hcount 140, none at 160 or 180.
  - With BULLET_OVF_COUNT_EN, ovf_count increments by 1.
- Scan restart: line_start(next_line=300), second line_start(next_line=10) at cycle 20 -> the list reflects line 10 only; swap occurs 33 cycles after the second pulse.
- Boundary wrap: entry vpos=2045, next_line=2047 -> hit; entry hpos=4090 -> hit at hcount 4095, no false hit at hcount 0..3.
